fetch_ctrl: RTL and testbench

Pipeline fetch sequencer for the 5-stage RISC core. It drives the IF stage's PC_write/PCSrc/PC_Branch controls and the IF/ID and ID/EX write and flush controls.
- Sequences post-reset boot hold.
- Inserts load-use stall bubbles.
- Handles taken-branch redirects with IF/ID and ID/EX flush.
- Honours an external freeze request from the memory side.

---
 rtl/fetch_ctrl_pkg.sv | 28 ++
 rtl/fetch_ctrl_load_use_detect.sv | 19 +
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, the x0
// register index and the canonical front-end control bundles.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    REDIR = 2'd3
  } fc_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic flush_if_id;
    logic flush_id_ex;
  } fc_ctrl_t;

  localparam fc_ctrl_t CTRL_BOOT   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam fc_ctrl_t CTRL_RUN    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam fc_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam fc_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam fc_ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/fetch_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the operands read in ID.
// Kept standalone so the same compare can be reused outside the sequencer.
module load_use_detect
  import fetch_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign load_use = mem_read & (rd != REG_ZERO) &
                    ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: boot hold, load-use bubbles, branch redirects and freeze.
// Define FETCH_CTRL_PERF_EN to add the stall/flush performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            freeze,
  input  logic            id_ex_mem_read,
  input  logic [4:0]      id_ex_rd,
  input  logic [4:0]      if_id_rs1,
  input  logic [4:0]      if_id_rs2,
  input  logic            if_id_use_rs1,
  input  logic            if_id_use_rs2,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target_ex,
  output logic            PC_write,
  output logic            PCSrc,
  output logic [XLEN-1:0] PC_Branch,
  output logic            IF_ID_write,
  output logic            flush_if_id,
  output logic            flush_id_ex
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam logic [31:0] BOOT_LAST = (BOOT_CYCLES > 0) ? 32'(BOOT_CYCLES - 1) : 32'd0;

  fc_state_t   state_r;
  fc_state_t   next_state_s;
  logic [31:0] boot_cnt_r;
  fc_ctrl_t    ctrl_s;
  logic        load_use_s;
  logic        redirect_s;
  logic        stall_s;

  load_use_detect u_load_use_detect (
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .rs1      (if_id_rs1),
    .rs2      (if_id_rs2),
    .use_rs1  (if_id_use_rs1),
    .use_rs2  (if_id_use_rs2),
    .load_use (load_use_s)
  );

  // Next-state and control decode; priority is freeze > redirect > load-use
  always_comb begin
    ctrl_s       = CTRL_BOOT;
    next_state_s = state_r;
    redirect_s   = 1'b0;
    stall_s      = 1'b0;
    if (!reset) begin
      ctrl_s       = CTRL_BOOT;
      next_state_s = BOOT;
    end else begin
      case (state_r)
        BOOT: begin
          ctrl_s       = CTRL_BOOT;
          next_state_s = (boot_cnt_r == BOOT_LAST) ? RUN : BOOT;
        end
        RUN, STALL: begin
          if (freeze) begin
            ctrl_s = CTRL_FREEZE;
          end else if (branch_taken_ex) begin
            ctrl_s       = CTRL_REDIR;
            redirect_s   = 1'b1;
            next_state_s = REDIR;
          end else if (load_use_s && (state_r == RUN)) begin
            ctrl_s       = CTRL_BUBBLE;
            stall_s      = 1'b1;
            next_state_s = STALL;
          end else begin
            ctrl_s       = CTRL_RUN;
            next_state_s = RUN;
          end
        end
        REDIR: begin
          // EX holds the bubble from the redirect, so its branch flag is stale
          if (freeze) begin
            ctrl_s = CTRL_FREEZE;
          end else begin
            ctrl_s       = CTRL_RUN;
            next_state_s = RUN;
          end
        end
        default: begin
          ctrl_s       = CTRL_BOOT;
          next_state_s = BOOT;
        end
      endcase
    end
  end

  assign PC_write    = ctrl_s.pc_write;
  assign PCSrc       = ctrl_s.pc_src;
  assign IF_ID_write = ctrl_s.if_id_write;
  assign flush_if_id = ctrl_s.flush_if_id;
  assign flush_id_ex = ctrl_s.flush_id_ex;
  assign PC_Branch   = ctrl_s.pc_src ? branch_target_ex : {XLEN{1'b0}};

  // State register and boot hold counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= (BOOT_CYCLES == 0) ? RUN : BOOT;
      boot_cnt_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == BOOT) begin
        boot_cnt_r <= boot_cnt_r + 32'd1;
      end else begin
        boot_cnt_r <= boot_cnt_r;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Performance counters; frozen cycles never assert stall or redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_s};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect_s};
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
// Control vector order: {PC_write, PCSrc, IF_ID_write, flush_if_id, flush_id_ex}.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        if_id_use_rs1;
  logic        if_id_use_rs2;
  logic        branch_taken_ex;
  logic [31:0] branch_target_ex;
  logic        PC_write;
  logic        PCSrc;
  logic [31:0] PC_Branch;
  logic        IF_ID_write;
  logic        flush_if_id;
  logic        flush_id_ex;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  logic [4:0] ctrl;
  assign ctrl = {PC_write, PCSrc, IF_ID_write, flush_if_id, flush_id_ex};

  localparam logic [4:0] C_BOOT   = 5'b00011;
  localparam logic [4:0] C_RUN    = 5'b10100;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_BUBBLE = 5'b00001;
  localparam logic [4:0] C_REDIR  = 5'b11111;

  fetch_ctrl #(.BOOT_CYCLES(2), .XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .freeze           (freeze),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_rd         (id_ex_rd),
    .if_id_rs1        (if_id_rs1),
    .if_id_rs2        (if_id_rs2),
    .if_id_use_rs1    (if_id_use_rs1),
    .if_id_use_rs2    (if_id_use_rs2),
    .branch_taken_ex  (branch_taken_ex),
    .branch_target_ex (branch_target_ex),
    .PC_write         (PC_write),
    .PCSrc            (PCSrc),
    .PC_Branch        (PC_Branch),
    .IF_ID_write      (IF_ID_write),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One active edge, then return to the falling edge to drive and sample
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    freeze           = 1'b0;
    id_ex_mem_read   = 1'b0;
    id_ex_rd         = 5'd0;
    if_id_rs1        = 5'd0;
    if_id_rs2        = 5'd0;
    if_id_use_rs1    = 1'b0;
    if_id_use_rs2    = 1'b0;
    branch_taken_ex  = 1'b0;
    branch_target_ex = 32'd0;
  endtask

  task automatic test_perf(input string tag);
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'(exp_stall)) begin
      failures++;
      $display("FAIL %s_stall_cnt got=%0d exp=%0d", tag, perf_stall_cnt, exp_stall);
    end
    checks++;
    if (perf_flush_cnt !== 32'(exp_flush)) begin
      failures++;
      $display("FAIL %s_flush_cnt got=%0d exp=%0d", tag, perf_flush_cnt, exp_flush);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    branch_taken_ex  = 1'b1;
    branch_target_ex = 32'h0000_0040;
    #1;
    checks++;
    if (ctrl !== C_BOOT || PC_Branch !== 32'd0) begin
      failures++;
      $display("FAIL reset_out ctrl=%b exp=%b pcb=%h exp=0", ctrl, C_BOOT, PC_Branch);
    end
    repeat (3) tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BOOT) begin failures++; $display("FAIL boot_hold1 ctrl=%b exp=%b", ctrl, C_BOOT); end
    tick();
    checks++;
    if (ctrl !== C_BOOT) begin failures++; $display("FAIL boot_hold2 ctrl=%b exp=%b", ctrl, C_BOOT); end
    tick();
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL boot_run ctrl=%b exp=%b", ctrl, C_RUN); end
    exp_stall = 0;
    exp_flush = 0;
    test_perf("reset");
  endtask

  task automatic test_load_use();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd5; if_id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BUBBLE) begin failures++; $display("FAIL lu_bubble ctrl=%b exp=%b", ctrl, C_BUBBLE); end
    exp_stall++;
    tick();
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL lu_stall_masked ctrl=%b exp=%b", ctrl, C_RUN); end
    idle_inputs();
    tick();
    #1;
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL lu_back_run ctrl=%b exp=%b", ctrl, C_RUN); end
    test_perf("load_use");
  endtask

  task automatic test_no_hazard();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL x0_no_stall ctrl=%b exp=%b", ctrl, C_RUN); end
    tick();
    idle_inputs();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs2 = 5'd7; if_id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL unused_rs2 ctrl=%b exp=%b", ctrl, C_RUN); end
    if_id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BUBBLE) begin failures++; $display("FAIL used_rs2 ctrl=%b exp=%b", ctrl, C_BUBBLE); end
    exp_stall++;
    tick();
    idle_inputs();
    tick();
    test_perf("no_hazard");
  endtask

  task automatic test_redirect();
    branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0040;
    #1;
    checks++;
    if (ctrl !== C_REDIR || PC_Branch !== 32'h40) begin
      failures++;
      $display("FAIL redir ctrl=%b exp=%b pcb=%h exp=00000040", ctrl, C_REDIR, PC_Branch);
    end
    exp_flush++;
    tick();
    checks++;
    if (ctrl !== C_RUN || PC_Branch !== 32'd0) begin
      failures++;
      $display("FAIL redir_stale_masked ctrl=%b exp=%b pcb=%h exp=0", ctrl, C_RUN, PC_Branch);
    end
    tick();
    checks++;
    if (ctrl !== C_REDIR) begin failures++; $display("FAIL back_to_back ctrl=%b exp=%b", ctrl, C_REDIR); end
    exp_flush++;
    tick();
    idle_inputs();
    tick();
    test_perf("redirect");
  endtask

  task automatic test_branch_load_use();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9; if_id_use_rs1 = 1'b1;
    branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0080;
    #1;
    checks++;
    if (ctrl !== C_REDIR || PC_Branch !== 32'h80) begin
      failures++;
      $display("FAIL br_lu_redir ctrl=%b exp=%b pcb=%h exp=00000080", ctrl, C_REDIR, PC_Branch);
    end
    exp_flush++;
    tick();
    branch_taken_ex = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL br_lu_masked ctrl=%b exp=%b", ctrl, C_RUN); end
    idle_inputs();
    tick();
    test_perf("br_lu");
  endtask

  task automatic test_freeze();
    freeze = 1'b1; branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctrl !== C_FREEZE) begin
        failures++;
        $display("FAIL freeze_hold%0d ctrl=%b exp=%b", i, ctrl, C_FREEZE);
      end
      tick();
    end
    freeze = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_REDIR || PC_Branch !== 32'h100) begin
      failures++;
      $display("FAIL freeze_release ctrl=%b exp=%b pcb=%h exp=00000100", ctrl, C_REDIR, PC_Branch);
    end
    exp_flush++;
    tick();
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL freeze_once ctrl=%b exp=%b", ctrl, C_RUN); end
    idle_inputs();
    tick();
    test_perf("freeze");
  endtask

  task automatic test_midreset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3; if_id_use_rs1 = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_BOOT) begin failures++; $display("FAIL midreset_comb ctrl=%b exp=%b", ctrl, C_BOOT); end
    tick();
    reset  = 1'b1;
    freeze = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    checks++;
    if (ctrl !== C_BOOT) begin failures++; $display("FAIL midreset_boot ctrl=%b exp=%b", ctrl, C_BOOT); end
    test_perf("midreset");
    tick();
    checks++;
    if (ctrl !== C_BOOT) begin failures++; $display("FAIL boot_freeze_hold ctrl=%b exp=%b", ctrl, C_BOOT); end
    tick();
    checks++;
    if (ctrl !== C_FREEZE) begin failures++; $display("FAIL boot_freeze_run ctrl=%b exp=%b", ctrl, C_FREEZE); end
    freeze = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_RUN) begin failures++; $display("FAIL boot_freeze_release ctrl=%b exp=%b", ctrl, C_RUN); end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_branch_load_use();
    test_freeze();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
